// File: rtl/axi4l_pkg.sv
// AXI4-Lite channel field types and response codes shared by masters and slaves.
package axi4l_pkg;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;
   typedef logic [1:0]  resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle: AW/W/B/AR/R channels with master and slave views.
interface axi4l_if
   import axi4l_pkg::*;
(
   input logic aclk,
   input logic aresetn
);
   logic       awvalid;
   logic       awready;
   addr_t      awaddr;
   logic [2:0] awprot;
   logic       wvalid;
   logic       wready;
   data_t      wdata;
   strb_t      wstrb;
   logic       bvalid;
   logic       bready;
   resp_t      bresp;
   logic       arvalid;
   logic       arready;
   addr_t      araddr;
   logic [2:0] arprot;
   logic       rvalid;
   logic       rready;
   data_t      rdata;
   resp_t      rresp;

   modport master (
      input  aclk, aresetn, awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready
   );

   modport slave (
      input  aclk, aresetn, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr,
             arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/obi_axi4l_master.sv
// Ibex data-port (req/gnt/rvalid) to AXI4-Lite master bridge, one transaction in flight.
// AXI error responses surface as data_err alongside the data_rvalid pulse.
module obi_axi4l_master #(
   parameter logic [2:0] PROT = 3'b000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        data_req,
   output logic        data_gnt,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err,
   axi4l_if.master     axi
);
   import axi4l_pkg::*;

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R} state_t;

   state_t state_q, state_d;
   addr_t  addr_q, addr_d;
   data_t  wdata_q, wdata_d;
   strb_t  be_q, be_d;
   logic   awvalid_q, awvalid_d;
   logic   wvalid_q, wvalid_d;
   logic   arvalid_q, arvalid_d;
   logic   bready_q, rready_q;
   logic   rvalid_q, rvalid_d;
   logic   err_q, err_d;
   data_t  rdata_q, rdata_d;

   assign data_gnt = data_req && (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rvalid_d  = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (data_req) begin
               addr_d  = data_addr;
               wdata_d = data_wdata;
               be_d    = data_be;
               if (data_we) begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR: begin
            // AW and W retire independently; leave only when both valids have dropped
            if (awvalid_q && axi.awready) awvalid_d = 1'b0;
            if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d)  state_d   = WR_B;
         end
         WR_B: begin
            if (axi.bvalid) begin
               rvalid_d = 1'b1;
               err_d    = (axi.bresp != RESP_OKAY);
               rdata_d  = '0;
               state_d  = IDLE;
            end
         end
         RD: begin
            if (arvalid_q && axi.arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (axi.rvalid) begin
               rvalid_d = 1'b1;
               err_d    = (axi.rresp != RESP_OKAY);
               rdata_d  = axi.rdata;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         // ready lines are registered decodes of the state being entered
         bready_q  <= (state_d == WR_B);
         rready_q  <= (state_d == RD_R);
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awprot  = PROT;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = be_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arprot  = PROT;
   assign axi.rready  = rready_q;

   assign data_rvalid = rvalid_q;
   assign data_err    = err_q;
   assign data_rdata  = rdata_q;
endmodule

// File: tb/tb_obi_axi4l_master.sv
// Directed bench for obi_axi4l_master: scripted AXI4-Lite slave with per-channel stalls.
module tb_obi_axi4l_master;
   import axi4l_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        data_req, data_gnt, data_we, data_rvalid, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;

   always #5 aclk = ~aclk;

   axi4l_if axi (.aclk(aclk), .aresetn(aresetn));

   obi_axi4l_master #(.PROT(3'b000)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .data_err(data_err), .axi(axi)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // cycle counter and core-side monitor
   int          cyc = 0;
   int          gnt_q[$];
   int          rv_cyc[$];
   logic [31:0] rv_data[$];
   logic        rv_err[$];

   always @(posedge aclk) cyc <= cyc + 1;

   always @(negedge aclk) begin
      if (aresetn) begin
         if (data_gnt) gnt_q.push_back(cyc);
         if (data_rvalid) begin
            rv_cyc.push_back(cyc);
            rv_data.push_back(data_rdata);
            rv_err.push_back(data_err);
         end
      end
   end

   // scripted slave
   int    aw_stall = 0, w_stall = 0, ar_stall = 0, resp_stall = 0;
   resp_t s_resp = RESP_OKAY;
   data_t s_rdata = '0;
   addr_t log_awaddr, log_araddr;
   data_t log_wdata;
   strb_t log_wstrb;
   int    b_count = 0;
   bit    aw_hs, w_hs, b_hs, ar_hs, r_hs;
   bit    got_aw, got_w, b_act, r_act;
   int    aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;

   initial begin
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = RESP_OKAY;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = RESP_OKAY;
      got_aw = 0; got_w = 0; b_act = 0; r_act = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
      forever begin
         @(negedge aclk);
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         b_hs  = axi.bvalid && axi.bready;
         ar_hs = axi.arvalid && axi.arready;
         r_hs  = axi.rvalid && axi.rready;
         if (aw_hs) log_awaddr = axi.awaddr;
         if (w_hs) begin log_wdata = axi.wdata; log_wstrb = axi.wstrb; end
         if (ar_hs) log_araddr = axi.araddr;
         if (b_hs) b_count++;
         @(posedge aclk);
         #1;
         if (!aresetn) begin
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
            got_aw = 0; got_w = 0; b_act = 0; r_act = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
         end else begin
            if (aw_hs) got_aw = 1;
            if (w_hs) got_w = 1;
            if (b_hs) begin axi.bvalid = 0; b_act = 0; end
            if (r_hs) begin axi.rvalid = 0; r_act = 0; end
            axi.awready = axi.awvalid && (aw_cnt >= aw_stall);
            aw_cnt      = axi.awvalid ? aw_cnt + 1 : 0;
            axi.wready  = axi.wvalid && (w_cnt >= w_stall);
            w_cnt       = axi.wvalid ? w_cnt + 1 : 0;
            axi.arready = axi.arvalid && (ar_cnt >= ar_stall);
            ar_cnt      = axi.arvalid ? ar_cnt + 1 : 0;
            if (got_aw && got_w && !b_act) begin
               b_act = 1; b_wait = resp_stall; got_aw = 0; got_w = 0; axi.bresp = s_resp;
            end
            if (b_act && !axi.bvalid) begin
               if (b_wait == 0) axi.bvalid = 1;
               else b_wait--;
            end
            if (ar_hs && !r_act) begin r_act = 1; r_wait = resp_stall; end
            if (r_act && !axi.rvalid) begin
               if (r_wait == 0) begin axi.rvalid = 1; axi.rdata = s_rdata; axi.rresp = s_resp; end
               else r_wait--;
            end
         end
      end
   end

   // present a request and wait for its grant; returns just after the following edge
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input bit keep);
      bit got = 0;
      @(posedge aclk);
      #1;
      data_req = 1; data_we = we; data_addr = addr; data_be = be; data_wdata = wd;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge aclk);
         got = data_gnt;
      end
      check("grant_seen", got, 1);
      @(posedge aclk);
      #1;
      if (!keep) data_req = 0;
   endtask

   task automatic wait_rv(input int n);
      for (int i = 0; i < 100 && rv_cyc.size() < n; i++) begin
         @(posedge aclk);
         #1;
      end
      check("rvalid_count", rv_cyc.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int g, n;

   initial begin
      data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
      repeat (3) @(negedge aclk);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_wvalid", axi.wvalid, 0);
      check("rst_arvalid", axi.arvalid, 0);
      check("rst_bready", axi.bready, 0);
      check("rst_rready", axi.rready, 0);
      check("rst_rvalid", data_rvalid, 0);
      check("rst_err", data_err, 0);
      check("rst_rdata", data_rdata, 0);
      aresetn = 1;

      // single write, always-ready slave
      issue(1, 32'h0, 4'hF, 32'h0000_000A, 0);
      g = gnt_q.size() - 1;
      @(negedge aclk);
      check("w1_awvalid", axi.awvalid, 1);
      check("w1_wvalid", axi.wvalid, 1);
      check("w1_awaddr", axi.awaddr, 32'h0);
      check("w1_wdata", axi.wdata, 32'h0000_000A);
      check("w1_wstrb", axi.wstrb, 4'hF);
      check("w1_awprot", axi.awprot, 3'b000);
      wait_rv(1);
      check("w1_latency", rv_cyc[0] - gnt_q[g], 3);
      check("w1_err", rv_err[0], 0);
      check("w1_rdata", rv_data[0], 0);

      // read back
      s_rdata = 32'h0000_000A; s_resp = RESP_OKAY;
      issue(0, 32'h0, 4'hF, 32'h0, 0);
      g = gnt_q.size() - 1;
      @(negedge aclk);
      check("r1_arvalid", axi.arvalid, 1);
      check("r1_araddr", axi.araddr, 32'h0);
      check("r1_awvalid", axi.awvalid, 0);
      wait_rv(2);
      check("r1_latency", rv_cyc[1] - gnt_q[g], 3);
      check("r1_rdata", rv_data[1], 32'h0000_000A);
      check("r1_err", rv_err[1], 0);

      // AW stalled 3 cycles, W accepted at once
      aw_stall = 3;
      n = b_count;
      issue(1, 32'h10, 4'h3, 32'h1234_5678, 0);
      g = gnt_q.size() - 1;
      @(negedge aclk);
      check("w2_c1_wvalid", axi.wvalid, 1);
      @(negedge aclk);
      check("w2_c2_wvalid", axi.wvalid, 0);
      check("w2_c2_awvalid", axi.awvalid, 1);
      check("w2_c2_awaddr", axi.awaddr, 32'h10);
      @(negedge aclk);
      check("w2_c3_awvalid", axi.awvalid, 1);
      check("w2_c3_awaddr", axi.awaddr, 32'h10);
      wait_rv(3);
      check("w2_latency", rv_cyc[2] - gnt_q[g], 6);
      check("w2_err", rv_err[2], 0);
      repeat (5) @(posedge aclk);
      #1;
      check("w2_b_count", b_count - n, 1);
      check("w2_rv_total", rv_cyc.size(), 3);
      check("w2_log_awaddr", log_awaddr, 32'h10);
      check("w2_log_wdata", log_wdata, 32'h1234_5678);
      check("w2_log_wstrb", log_wstrb, 4'h3);
      aw_stall = 0;

      // back-to-back: read then write with data_req held high
      s_rdata = 32'h0000_55AA;
      issue(0, 32'h24, 4'hF, 32'h0, 1);
      g = gnt_q.size() - 1;
      data_we = 1; data_addr = 32'h20; data_be = 4'hC; data_wdata = 32'hDEAD_BEEF;
      wait_rv(4);
      data_req = 0;
      check("b2b_rd_rdata", rv_data[3], 32'h0000_55AA);
      check("b2b_rd_araddr", log_araddr, 32'h24);
      check("b2b_gnt_count", gnt_q.size() - g, 2);
      check("b2b_gnt_at_rvalid", gnt_q[g + 1], rv_cyc[3]);
      @(negedge aclk);
      check("b2b_wr_awaddr", axi.awaddr, 32'h20);
      check("b2b_wr_wdata", axi.wdata, 32'hDEAD_BEEF);
      check("b2b_wr_wstrb", axi.wstrb, 4'hC);
      wait_rv(5);
      check("b2b_wr_rdata", rv_data[4], 0);
      check("b2b_wr_err", rv_err[4], 0);
      check("b2b_wr_latency", rv_cyc[4] - gnt_q[g + 1], 3);

      // SLVERR read with slow R, request held high throughout
      s_resp = RESP_SLVERR; resp_stall = 5; s_rdata = 32'h0000_0BAD;
      n = rv_cyc.size();
      issue(0, 32'h4, 4'hF, 32'h0, 1);
      g = gnt_q.size() - 1;
      @(negedge aclk);
      check("r2_arvalid", axi.arvalid, 1);
      check("r2_araddr", axi.araddr, 32'h4);
      @(negedge aclk);
      check("r2_rready", axi.rready, 1);
      wait_rv(n + 1);
      data_req = 0;
      check("r2_latency", rv_cyc[n] - gnt_q[g], 8);
      check("r2_err", rv_err[n], 1);
      check("r2_rdata", rv_data[n], 32'h0000_0BAD);
      check("r2_gnt_count", gnt_q.size() - g, 2);
      check("r2_regrant_at_rvalid", gnt_q[g + 1], rv_cyc[n]);
      wait_rv(n + 2);
      check("r2b_err", rv_err[n + 1], 1);

      // reset while waiting in WR_B
      s_resp = RESP_OKAY; resp_stall = 10;
      issue(1, 32'h30, 4'hF, 32'h0000_0011, 0);
      @(negedge aclk);
      @(negedge aclk);
      check("rst_pre_bready", axi.bready, 1);
      check("rst_pre_err", data_err, 1);
      #2 aresetn = 0;
      #1;
      check("arst_bready", axi.bready, 0);
      check("arst_awvalid", axi.awvalid, 0);
      check("arst_wvalid", axi.wvalid, 0);
      check("arst_arvalid", axi.arvalid, 0);
      check("arst_rready", axi.rready, 0);
      check("arst_rvalid", data_rvalid, 0);
      check("arst_err", data_err, 0);
      check("arst_rdata", data_rdata, 0);
      n = rv_cyc.size();
      repeat (3) @(negedge aclk);
      aresetn = 1;
      resp_stall = 0; s_rdata = 32'h0000_0077;
      repeat (3) @(negedge aclk);
      check("arst_no_resp", rv_cyc.size(), n);
      issue(0, 32'h8, 4'hF, 32'h0, 0);
      g = gnt_q.size() - 1;
      wait_rv(n + 1);
      check("post_rst_rdata", rv_data[n], 32'h0000_0077);
      check("post_rst_err", rv_err[n], 0);
      check("post_rst_latency", rv_cyc[n] - gnt_q[g], 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
